step4_normalize_pack: RTL and testbench
=======================================

STEP4_NORMALIZE_PACK -- requirements
Module: step4_normalize_pack

Interface
REQ-001 SHALL have port: clock  input  1  rising-edge clock.
REQ-002 SHALL have port: resetn  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: in_valid  input  1  upstream adder-status word valid.
REQ-004 SHALL have port: in_ready  output  1  block can accept a word.
REQ-005 SHALL have port: in_adder_out  input  24  adder magnitude; bit 23 = hidden-bit position.
REQ-006 SHALL have port: in_ov_sign  input  1  adder carry-out; true magnitude = {1, in_adder_out}.
REQ-007 SHALL have port: in_adder_out_sign  input  1  result sign.
REQ-008 SHALL have port: in_current_ex  input  8  biased exponent aligned to in_adder_out.
REQ-009 SHALL have port: out_valid  output  1  out_result holds a packed result.
REQ-010 SHALL have port: out_ready  input  1  downstream accepts the result.
REQ-011 SHALL have port: out_result  output  32  IEEE-754 single {sign, exp[7:0], frac[22:0]}.
REQ-012 SHALL have port: out_flags  output  3  {inf, zero, denormal} for out_result.

Function
REQ-013 SHALL implement FSM IDLE, NORM, DONE; in_ready = (state == IDLE).
REQ-014 In IDLE, in_valid = 1 SHALL capture all inputs into working registers (mant, ov, sign, ex) and move to NORM on the same edge.
REQ-015 Each NORM cycle SHALL evaluate one rule, in priority order:
  a) ex == 255 -> pack exp 255, frac 0, flags inf.
  b) ov = 1 -> mant = {1, mant[23:1]} (LSB truncated), ex + 1; ex + 1 == 255 -> pack infinity, else pack normal.
  c) mant == 0 -> pack 0x00000000 with sign forced to 0; flags zero.
  d) mant[23] = 1 -> pack {sign, ex, mant[22:0]}.
  e) ex <= 1 and mant[23] = 0 -> pack {sign, 8'h00, mant[22:0]}; flags denormal.
  f) otherwise -> mant <<= 1, ex - 1; remain in NORM.
REQ-016 Any pack SHALL register out_result/out_flags, enter DONE and set out_valid on that edge.
REQ-017 Latency SHALL be 1 + k edges from the accept edge to out_valid, where k = number of left shifts (0..23).
REQ-018 Rounding SHALL be truncation only; no sticky/guard bits are kept.
REQ-019 In DONE, out_result, out_flags and out_valid SHALL hold stable until out_ready = 1.
REQ-020 out_valid & out_ready SHALL clear out_valid and return to IDLE; the next word is accepted no earlier than the following edge.
REQ-021 in_valid while not in IDLE SHALL be ignored; upstream holds the word until in_ready.
REQ-022 Shift count SHALL never exceed 23; a cycle counter or equivalent SHALL force pack rule e) as a safety bound.

Reset
REQ-023 resetn = 0 SHALL asynchronously set state IDLE, out_valid 0, out_result 0, out_flags 0, and clear working registers.
REQ-024 Reset asserted in NORM or DONE SHALL discard the in-flight word with no output.
REQ-025 After release, in_ready SHALL be 1 in the first cycle.

Structure
REQ-026 The shared MAC package SHALL hold MANT_W = 24, EXP_W = 8, EXP_MAX = 8'hFF and the FSM state encoding.
REQ-027 Packing (REQ-015 a–e result formation) SHALL be a combinational sub-module step4_pack; the FSM and registers stay in step4_normalize_pack.

Verification
REQ-028 Normal case: mant 0x800000, ov 0, ex 0x80, sign 0 -> out_result 0x40000000, flags 000, out_valid 1 edge after accept.
REQ-029 Carry case: mant 0x000000, ov 1, ex 0x7F, sign 0 -> 0x40000000 after 1 edge. Overflow case: ov 1, ex 0xFE -> 0x7F800000, flags inf.
REQ-030 Max shift: mant 0x000001, ov 0, ex 0x7F, sign 1 -> 0xB4000000 after exactly 24 edges.
REQ-031 Zero and denormal:
  - mant 0, sign 1 -> 0x00000000, flags zero.
  - mant 0x000100, ex 0x03 -> two shifts -> 0x00000400, flags denormal.
REQ-032 Backpressure and reset:
  - out_ready held 0 for 3 cycles -> out_result stable, in_ready 0, extra in_valid ignored.
  - resetn pulsed mid-NORM -> out_valid never asserted for that word; in_ready 1 after release.

Source files
------------

// File: rtl/step4_normalize_pack_pkg.sv
// Shared MAC constants and types for the step-4 normalize/pack stage.
package step4_normalize_pack_pkg;

  localparam int MANT_W = 24;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = MANT_W - 1;
  localparam int CNT_W  = 5;

  localparam logic [EXP_W-1:0] EXP_MAX   = 8'hFF;
  localparam logic [CNT_W-1:0] SHIFT_MAX = 5'd23;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NORM = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic inf;
    logic zero;
    logic denormal;
  } flags_t;

endpackage

// File: rtl/step4_pack.sv
// Combinational result formation for one normalize step: decides whether the
// working word can be packed this cycle and, if so, what the IEEE word is.
module step4_pack
  import step4_normalize_pack_pkg::*;
(
  input  logic [MANT_W-1:0] mant,
  input  logic              ov,
  input  logic              sign,
  input  logic [EXP_W-1:0]  ex,
  input  logic              force_denorm,
  output logic              do_pack,
  output logic [31:0]       result,
  output flags_t            flags
);

  logic [EXP_W-1:0] ex_inc;

  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    ex_inc  = ex + 8'd1;
    do_pack = 1'b1;
    result  = '0;
    flags   = '0;
    if (ex == EXP_MAX) begin
      result     = {sign, EXP_MAX, {FRAC_W{1'b0}}};
      flags.inf  = 1'b1;
    end else if (ov) begin
      // Carry-out: the hidden one moves to bit 24, so drop the LSB and bump ex.
      if (ex_inc == EXP_MAX) begin
        result    = {sign, EXP_MAX, {FRAC_W{1'b0}}};
        flags.inf = 1'b1;
      end else begin
        result = {sign, ex_inc, mant[MANT_W-1:1]};
      end
    end else if (mant == '0) begin
      flags.zero = 1'b1;
    end else if (mant[MANT_W-1]) begin
      result = {sign, ex, mant[FRAC_W-1:0]};
    end else if (ex <= 8'd1 || force_denorm) begin
      result         = {sign, {EXP_W{1'b0}}, mant[FRAC_W-1:0]};
      flags.denormal = 1'b1;
    end else begin
      do_pack = 1'b0;
    end
  end

endmodule

// File: rtl/step4_normalize_pack.sv
// Normalize/pack stage: accepts one adder-status word, left-shifts it one bit
// per cycle until packable, then holds the IEEE single result until taken.
module step4_normalize_pack
  import step4_normalize_pack_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] in_adder_out,
  input  logic              in_ov_sign,
  input  logic              in_adder_out_sign,
  input  logic [EXP_W-1:0]  in_current_ex,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result,
  output logic [2:0]        out_flags
);

  state_t            state, state_nxt;
  logic [MANT_W-1:0] mant;
  logic              ov;
  logic              sign;
  logic [EXP_W-1:0]  ex;
  logic [CNT_W-1:0]  shift_cnt;

  logic              do_pack;
  logic [31:0]       pack_result;
  flags_t            pack_flags;

  step4_pack u_pack (
    .mant         (mant),
    .ov           (ov),
    .sign         (sign),
    .ex           (ex),
    .force_denorm (shift_cnt == SHIFT_MAX),
    .do_pack      (do_pack),
    .result       (pack_result),
    .flags        (pack_flags)
  );

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid)  state_nxt = ST_NORM;
      ST_NORM: if (do_pack)   state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
  end

  // NOTE: the working registers are plain flops, so clearing them on reset is
  // cheap and keeps a discarded in-flight word from leaking into the next one.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mant       <= '0;
      ov         <= 1'b0;
      sign       <= 1'b0;
      ex         <= '0;
      shift_cnt  <= '0;
      out_result <= '0;
      out_flags  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            mant      <= in_adder_out;
            ov        <= in_ov_sign;
            sign      <= in_adder_out_sign;
            ex        <= in_current_ex;
            shift_cnt <= '0;
          end
        end
        ST_NORM: begin
          if (do_pack) begin
            out_result <= pack_result;
            out_flags  <= pack_flags;
          end else begin
            mant      <= {mant[MANT_W-2:0], 1'b0};
            ex        <= ex - 8'd1;
            shift_cnt <= shift_cnt + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_step4_normalize_pack.sv
// Directed bench for step4_normalize_pack: arithmetic reference model plus a
// per-cycle compare process over a queue of expected results.
module tb_step4_normalize_pack;

  logic        clock;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_adder_out;
  logic        in_ov_sign;
  logic        in_adder_out_sign;
  logic [7:0]  in_current_ex;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [2:0]  out_flags;

  step4_normalize_pack dut (
    .clock             (clock),
    .resetn            (resetn),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_adder_out      (in_adder_out),
    .in_ov_sign        (in_ov_sign),
    .in_adder_out_sign (in_adder_out_sign),
    .in_current_ex     (in_current_ex),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_result        (out_result),
    .out_flags         (out_flags)
  );

  typedef struct {
    logic [31:0] result;
    logic [2:0]  flags;
    int          lat;
    int          accept;
  } exp_t;

  typedef struct {
    logic [23:0] m;
    logic        ov;
    logic        s;
    logic [7:0]  e;
    logic [31:0] r;
    logic [2:0]  f;
    int          lat;
  } vec_t;

  exp_t exp_q[$];
  bit   head_seen;
  bit   done_sim;
  int   cyc;
  int   n_checks;
  int   n_errors;

  vec_t vecs[12] = '{
    '{24'h800000, 1'b0, 1'b0, 8'h80, 32'h40000000, 3'b000, 1},
    '{24'h000000, 1'b1, 1'b0, 8'h7F, 32'h40000000, 3'b000, 1},
    '{24'h000000, 1'b1, 1'b0, 8'hFE, 32'h7F800000, 3'b100, 1},
    '{24'h000001, 1'b0, 1'b1, 8'h7F, 32'hB4000000, 3'b000, 24},
    '{24'h000000, 1'b0, 1'b1, 8'h55, 32'h00000000, 3'b010, 1},
    '{24'h000100, 1'b0, 1'b0, 8'h03, 32'h00000400, 3'b001, 3},
    '{24'h123456, 1'b0, 1'b1, 8'hFF, 32'hFF800000, 3'b100, 1},
    '{24'hFFFFFF, 1'b1, 1'b1, 8'h10, 32'h88FFFFFF, 3'b000, 1},
    '{24'h400000, 1'b0, 1'b0, 8'h01, 32'h00400000, 3'b001, 1},
    '{24'h800000, 1'b0, 1'b1, 8'h00, 32'h80000000, 3'b000, 1},
    '{24'h345678, 1'b0, 1'b0, 8'h90, 32'h475159E0, 3'b000, 3},
    '{24'h000010, 1'b0, 1'b0, 8'h02, 32'h00000020, 3'b001, 2}
  };

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Value-level reference: count leading zeros, shift as far as the exponent
  // allows, and classify the outcome.
  function automatic exp_t model(input logic [23:0] m, input logic ov,
                                 input logic s, input logic [7:0] e);
    exp_t        r;
    int          lz;
    int          k;
    logic [23:0] mm;
    r.lat    = 1;
    r.flags  = 3'b000;
    r.result = 32'h0;
    r.accept = 0;
    if (e == 8'hFF) begin
      r.result = {s, 8'hFF, 23'd0};
      r.flags  = 3'b100;
    end else if (ov) begin
      if (e == 8'hFE) begin
        r.result = {s, 8'hFF, 23'd0};
        r.flags  = 3'b100;
      end else begin
        r.result = {s, e + 8'd1, m[23:1]};
      end
    end else if (m == 24'h0) begin
      r.flags = 3'b010;
    end else begin
      lz = 0;
      while (!m[23-lz]) lz++;
      k = (e > 8'd1) ? int'(e) - 1 : 0;
      if (lz < k) k = lz;
      mm    = m << k;
      r.lat = 1 + k;
      if (k == lz) begin
        r.result = {s, e - 8'(k), mm[22:0]};
      end else begin
        r.result = {s, 8'h00, mm[22:0]};
        r.flags  = 3'b001;
      end
    end
    return r;
  endfunction

  // Drives one word (starting just after a rising edge) and waits for accept.
  task automatic send(input vec_t v);
    exp_t x;
    int   waited;
    x = model(v.m, v.ov, v.s, v.e);
    check("model_result", x.result, v.r);
    check("model_flags", {29'd0, x.flags}, {29'd0, v.f});
    check("model_latency", x.lat, v.lat);
    in_adder_out      = v.m;
    in_ov_sign        = v.ov;
    in_adder_out_sign = v.s;
    in_current_ex     = v.e;
    in_valid          = 1'b1;
    waited = 0;
    do begin
      @(negedge clock);
      waited++;
    end while (!in_ready && waited < 200);
    if (!in_ready) begin
      check("accept_timeout", {31'd0, in_ready}, 32'd1);
      @(posedge clock); #1;
      in_valid = 1'b0;
    end else begin
      x.accept = cyc + 1;
      @(posedge clock); #1;
      exp_q.push_back(x);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
      head_seen = 1'b0;
    end
  endtask

  // Compare process: handshake state, result, flags and latency every cycle.
  initial begin
    forever begin
      @(negedge clock);
      if (resetn && !done_sim) begin
        check("in_ready", {31'd0, in_ready}, {31'd0, exp_q.size() == 0});
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            check("spurious_valid", {31'd0, out_valid}, 32'd0);
          end else begin
            check("out_result", out_result, exp_q[0].result);
            check("out_flags", {29'd0, out_flags}, {29'd0, exp_q[0].flags});
            if (!head_seen) begin
              check("latency", cyc - exp_q[0].accept, exp_q[0].lat);
              head_seen = 1'b1;
            end
            if (out_ready) begin
              void'(exp_q.pop_front());
              head_seen = 1'b0;
            end
          end
        end else if (exp_q.size() != 0 && cyc - exp_q[0].accept >= exp_q[0].lat) begin
          check("late_valid", {31'd0, out_valid}, 32'd1);
        end
      end
    end
  end

  initial begin
    int n;
    n_checks          = 0;
    n_errors          = 0;
    head_seen         = 1'b0;
    done_sim          = 1'b0;
    resetn            = 1'b0;
    in_valid          = 1'b0;
    in_adder_out      = '0;
    in_ov_sign        = 1'b0;
    in_adder_out_sign = 1'b0;
    in_current_ex     = '0;
    out_ready         = 1'b1;

    repeat (2) @(posedge clock);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_flags", {29'd0, out_flags}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    resetn = 1'b1;
    @(posedge clock); #1;

    foreach (vecs[i]) begin
      send(vecs[i]);
      wait_idle();
    end

    // Backpressure: result must hold while out_ready is low; stray in_valid ignored.
    out_ready = 1'b0;
    send(vecs[10]);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!out_valid && n < 50);
    check("bp_valid_seen", {31'd0, out_valid}, 32'd1);
    @(posedge clock); #1;
    in_adder_out  = 24'h0F0F0F;
    in_current_ex = 8'h22;
    in_valid      = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp_hold_result", out_result, 32'h475159E0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle();

    // Reset mid-normalization discards the word.
    send(vecs[3]);
    repeat (5) @(posedge clock);
    #1;
    resetn = 1'b0;
    exp_q.delete();
    head_seen = 1'b0;
    #2;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clock); #1;
    resetn = 1'b1;
    @(negedge clock);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (30) @(posedge clock);
    #1;

    send(vecs[0]);
    wait_idle();

    done_sim = 1'b1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
